// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings and the read/write channel FSM states.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_addr_dec.sv
// Combinational byte-address decoder: register index and window hit for one address channel.
module axi4_lite_addr_dec #(
    parameter int               ADDRESS    = 32,
    parameter int               DATA_WIDTH = 32,
    parameter int               NUM_REGS   = 16,
    parameter logic [ADDRESS-1:0] BASE_ADDR = '0,
    localparam int              IDX_W      = $clog2(NUM_REGS)
) (
    input  logic [ADDRESS-1:0] addr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               in_range_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);

    // One extra bit keeps the window limit from wrapping at the top of the address space.
    logic [ADDRESS:0] addr_ext_s;
    logic [ADDRESS:0] base_ext_s;
    logic [ADDRESS:0] limit_ext_s;
    logic [ADDRESS:0] offset_s;

    assign addr_ext_s  = {1'b0, addr_i};
    assign base_ext_s  = {1'b0, BASE_ADDR};
    assign limit_ext_s = base_ext_s + (ADDRESS+1)'(NUM_REGS * BYTES);
    assign offset_s    = addr_ext_s - base_ext_s;

    assign in_range_o = (addr_ext_s >= base_ext_s) && (addr_ext_s < limit_ext_s);
    assign idx_o      = IDX_W'(offset_s >> OFF_W);

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: one-entry AW/W holders, byte-strobed writes, single-beat reads.
module axi4_lite_regbank
    import axi4_lite_pkg::*;
#(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ADDRESS    = 32,
    parameter int                 NUM_REGS   = 16,
    parameter logic [ADDRESS-1:0] BASE_ADDR  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDRESS-1:0]             S_AWADDR,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    input  logic [ADDRESS-1:0]             S_ARADDR,
    input  logic                           S_ARVALID,
    output logic                           S_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_RDATA,
    output logic [1:0]                     S_RRESP,
    output logic                           S_RVALID,
    input  logic                           S_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);

    logic                  aw_full_q,  aw_full_d;
    logic [ADDRESS-1:0]    aw_addr_q,  aw_addr_d;
    logic                  w_full_q,   w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q,   w_data_d;
    logic [STRB_W-1:0]     w_strb_q,   w_strb_d;
    wr_state_e             wr_state_q, wr_state_d;
    logic                  awready_q,  awready_d;
    logic                  wready_q,   wready_d;
    logic                  bvalid_q,   bvalid_d;
    logic [1:0]            bresp_q,    bresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q,  arready_d;
    logic                  rvalid_q,   rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [1:0]            rresp_q,    rresp_d;

    logic [IDX_W-1:0]      aw_idx_s;
    logic                  aw_in_range_s;
    logic [IDX_W-1:0]      ar_idx_s;
    logic                  ar_in_range_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  ar_hs_s;
    logic                  commit_s;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_val[8*k +: 8];
            end
        end
        return res;
    endfunction

    axi4_lite_addr_dec #(
        .ADDRESS    (ADDRESS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_aw_dec (
        .addr_i     (aw_addr_q),
        .idx_o      (aw_idx_s),
        .in_range_o (aw_in_range_s)
    );

    axi4_lite_addr_dec #(
        .ADDRESS    (ADDRESS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_ar_dec (
        .addr_i     (S_ARADDR),
        .idx_o      (ar_idx_s),
        .in_range_o (ar_in_range_s)
    );

    assign aw_hs_s  = S_AWVALID & awready_q;
    assign w_hs_s   = S_WVALID  & wready_q;
    assign ar_hs_s  = S_ARVALID & arready_q;
    assign commit_s = aw_full_q & w_full_q & (wr_state_q == W_IDLE);

    // Write path next state: holder capture, commit into the bank, B channel handshake.
    always_comb begin
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = {NUM_REGS{1'b0}};

        if (aw_hs_s) begin
            aw_full_d = 1'b1;
            aw_addr_d = S_AWADDR;
        end else if (commit_s) begin
            aw_full_d = 1'b0;
        end else begin
            aw_full_d = aw_full_q;
        end

        if (w_hs_s) begin
            w_full_d = 1'b1;
            w_data_d = S_WDATA;
            w_strb_d = S_WSTRB;
        end else if (commit_s) begin
            w_full_d = 1'b0;
        end else begin
            w_full_d = w_full_q;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (commit_s) begin
                    wr_state_d = W_RESP;
                    bresp_d    = aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
                    if (aw_in_range_s && (w_strb_q != {STRB_W{1'b0}})) begin
                        regs_d[aw_idx_s]     = merge_bytes(regs_q[aw_idx_s], w_data_q, w_strb_q);
                        wr_pulse_d[aw_idx_s] = 1'b1;
                    end else begin
                        wr_pulse_d = {NUM_REGS{1'b0}};
                    end
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (S_BREADY) begin
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        // New AW/W only once the previous response has been retired.
        awready_d = ~aw_full_d & (wr_state_d == W_IDLE);
        wready_d  = ~w_full_d  & (wr_state_d == W_IDLE);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    // Write path state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= {ADDRESS{1'b0}};
            w_full_q   <= 1'b0;
            w_data_q   <= {DATA_WIDTH{1'b0}};
            w_strb_q   <= {STRB_W{1'b0}};
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // Read path next state; data comes from the pre-commit bank contents.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    rdata_d    = ar_in_range_s ? regs_q[ar_idx_s] : {DATA_WIDTH{1'b0}};
                    rresp_d    = ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_RREADY) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_DATA);
    end

    // Read path state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = bresp_q;
    assign S_ARREADY = arready_q;
    assign S_RVALID  = rvalid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;
    assign wr_pulse  = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Randomized self-checking bench for axi4_lite_regbank against an array-based register model.
module tb_axi4_lite_regbank;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [AW-1:0]   S_AWADDR;
    logic            S_AWVALID;
    logic            S_AWREADY;
    logic [DW-1:0]   S_WDATA;
    logic [DW/8-1:0] S_WSTRB;
    logic            S_WVALID;
    logic            S_WREADY;
    logic [1:0]      S_BRESP;
    logic            S_BVALID;
    logic            S_BREADY;
    logic [AW-1:0]   S_ARADDR;
    logic            S_ARVALID;
    logic            S_ARREADY;
    logic [DW-1:0]   S_RDATA;
    logic [1:0]      S_RRESP;
    logic            S_RVALID;
    logic            S_RREADY;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]   wr_pulse;

    axi4_lite_regbank #(
        .DATA_WIDTH (DW),
        .ADDRESS    (AW),
        .NUM_REGS   (NR),
        .BASE_ADDR  (BASE)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .reg_q     (reg_q),
        .wr_pulse  (wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulse_cnt = 0;
    logic [31:0] model [NR];

    // Count cycles carrying any write strobe, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (wr_pulse != '0) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + NR * 4);
    endfunction

    function automatic int ridx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return in_rng(a) ? model[ridx(a)] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int bdly);
        int aw_start, w_start, cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        logic [1:0] exp_resp, resp;
        logic [NR-1:0] exp_pulse;
        aw_start  = (lead > 0) ? lead : 0;
        w_start   = (lead < 0) ? -lead : 0;
        exp_resp  = in_rng(addr) ? 2'b00 : 2'b10;
        exp_pulse = (in_rng(addr) && strb != 4'h0) ? (NR'(1) << ridx(addr)) : '0;
        if (in_rng(addr)) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[ridx(addr)][8*k +: 8] = data[8*k +: 8];
            end
        end
        pulse_cnt = 0;
        S_AWADDR = addr;
        S_WDATA  = data;
        S_WSTRB  = strb;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc >= aw_start && !aw_done) S_AWVALID = 1'b1;
            if (cyc >= w_start && !w_done) S_WVALID = 1'b1;
            aw_hs = S_AWVALID && S_AWREADY;
            w_hs  = S_WVALID && S_WREADY;
            tick();
            cyc++;
            if (aw_hs) begin aw_done = 1'b1; S_AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; S_WVALID  = 1'b0; end
        end
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        chk("wr_hs", {aw_done, w_done}, 2'b11);
        cyc = 0;
        while (!S_BVALID && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bvalid_rise", S_BVALID, 1'b1);
        chk("wr_pulse_at_b", wr_pulse, exp_pulse);
        resp = S_BRESP;
        chk("bresp", resp, exp_resp);
        for (int i = 0; i < bdly; i++) begin
            tick();
            chk("bvalid_hold", S_BVALID, 1'b1);
            chk("bresp_hold", S_BRESP, resp);
            chk("aw_w_blocked", {S_AWREADY, S_WREADY}, 2'b00);
        end
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        chk("bvalid_drop", S_BVALID, 1'b0);
        chk("wr_pulse_cycles", pulse_cnt, (exp_pulse != '0) ? 1 : 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int start_dly, input int rdly,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit done, hs;
        repeat (start_dly) tick();
        S_ARADDR  = addr;
        S_ARVALID = 1'b1;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            hs = S_ARREADY;
            tick();
            cyc++;
            if (hs) done = 1'b1;
        end
        S_ARVALID = 1'b0;
        chk("ar_hs", done, 1'b1);
        chk("rvalid_latency", S_RVALID, 1'b1);
        chk("arready_busy", S_ARREADY, 1'b0);
        data = S_RDATA;
        resp = S_RRESP;
        for (int i = 0; i < rdly; i++) begin
            tick();
            chk("rvalid_hold", S_RVALID, 1'b1);
            chk("rdata_hold", S_RDATA, data);
        end
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
        chk("rvalid_drop", S_RVALID, 1'b0);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), reg_q[i*DW +: DW], model[i]);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] addr;
        int          idx;
        int          cyc;

        ARESET = 1'b1;
        S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
        S_BREADY = 1'b0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        repeat (2) tick();
        chk("rst_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
        chk("rst_valids", {S_BVALID, S_RVALID}, 2'b00);
        chk("rst_resps", {S_BRESP, S_RRESP}, 4'h0);
        chk("rst_rdata", S_RDATA, 32'h0);
        chk("rst_pulse", wr_pulse, '0);
        check_bank("rst");
        ARESET = 1'b0;
        tick();
        chk("rel_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

        // Basic write then read-back.
        axi_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_read(BASE + 32'h8, 0, 0, d, r);
        chk("basic_rdata", d, 32'hDEAD_BEEF);
        chk("basic_rresp", r, 2'b00);

        // W arrives three cycles ahead of AW with a partial strobe.
        axi_write(BASE, 32'h1122_3344, 4'hF, 0, 1);
        axi_write(BASE, 32'hAABB_CCDD, 4'b0101, 3, 0);
        chk("merge_reg0", reg_q[31:0], 32'h11BB_33DD);
        cyc = 0;
        repeat (3) begin
            tick();
            if (S_BVALID) cyc++;
        end
        chk("single_bvalid", cyc, 0);

        // One past the top of the window.
        axi_write(BASE + NR * 4, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_read(BASE + NR * 4, 0, 0, d, r);
        chk("oor_rdata", d, 32'h0);
        chk("oor_rresp", r, 2'b10);
        check_bank("oor");

        // Back-pressure on both response channels.
        axi_write(BASE + 32'hC, 32'h0BAD_F00D, 4'hF, -2, 5);
        axi_read(BASE + 32'hC, 0, 5, d, r);
        chk("bp_rdata", d, 32'h0BAD_F00D);

        // Read handshake in the same cycle as the write commit.
        axi_write(BASE + 32'h4, 32'h5, 4'hF, 0, 0);
        fork
            axi_write(BASE + 32'h4, 32'h9, 4'hF, 0, 0);
            axi_read(BASE + 32'h4, 1, 0, d, r);
        join
        chk("same_cycle_old", d, 32'h5);
        axi_read(BASE + 32'h4, 0, 0, d, r);
        chk("same_cycle_new", d, 32'h9);

        // Randomized traffic, including strobe-zero writes and both out-of-range sides.
        for (int it = 0; it < 60; it++) begin
            idx  = $urandom_range(0, 17);
            addr = (idx == 17) ? (BASE - 32'd4) : (BASE + idx * 4);
            addr = addr + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 6) - 3, $urandom_range(0, 3));
                if (in_rng(addr)) chk("rand_reg", reg_q[ridx(addr)*DW +: DW], model[ridx(addr)]);
            end else begin
                axi_read(addr, 0, $urandom_range(0, 3), d, r);
                chk("rand_rdata", d, exp_rd(addr));
                chk("rand_rresp", r, in_rng(addr) ? 2'b00 : 2'b10);
            end
        end
        check_bank("rand");

        // Reset with both responses pending.
        S_AWADDR = BASE + 32'hC; S_WDATA = 32'h1234_5678; S_WSTRB = 4'hF;
        S_ARADDR = BASE;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        cyc = 0;
        while (!(S_BVALID && S_RVALID) && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("pending_both", {S_BVALID, S_RVALID}, 2'b11);
        ARESET = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        chk("mid_rst_valids", {S_BVALID, S_RVALID}, 2'b00);
        chk("mid_rst_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
        check_bank("mid_rst");
        ARESET = 1'b0;
        tick();
        chk("mid_rel_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

        // A captured AW must not survive reset.
        S_AWADDR = BASE + 32'h1C;
        S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        tick();
        axi_write(BASE + 32'h24, 32'hCAFE_0001, 4'hF, 0, 0);
        check_bank("stale_aw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_regbank.md
AXI4_LITE_REGBANK -- requirements
Module: axi4_lite_regbank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (32 or 64 only).
REQ-002 SHALL have parameter ADDRESS, default 32, address bus width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count (power of two, 2..256).
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of register 0 (aligned to NUM_REGS*DATA_WIDTH/8).
REQ-005 SHALL have ports, clock and reset first: ACLK in 1 clock; ARESET in 1 sync active-high reset; S_AWADDR in ADDRESS; S_AWVALID in 1; S_AWREADY out 1; S_WDATA in DATA_WIDTH; S_WSTRB in DATA_WIDTH/8; S_WVALID in 1; S_WREADY out 1; S_BRESP out 2; S_BVALID out 1; S_BREADY in 1; S_ARADDR in ADDRESS; S_ARVALID in 1; S_ARREADY out 1; S_RDATA out DATA_WIDTH; S_RRESP out 2; S_RVALID out 1; S_RREADY in 1; reg_q out NUM_REGS*DATA_WIDTH, all register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]; wr_pulse out NUM_REGS, one-cycle strobe per register written.
REQ-006 One clock (ACLK); reset is synchronous and active-high (ARESET); all state updates on rising ACLK only.

Function
REQ-007 Register index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-008 Address in range iff BASE_ADDR <= addr < BASE_ADDR + NUM_REGS*DATA_WIDTH/8; out of range -> RESP 2'b10 (SLVERR), no register change, RDATA all zeros.
REQ-009 In-range access -> RESP 2'b00 (OKAY).
REQ-010 Write path: AW and W captured independently into one-entry holding registers; AWREADY high while AW holder empty, WREADY high while W holder empty; either may arrive first or both in the same cycle.
REQ-011 Register write commits the cycle after both holders are full and B channel is idle; each byte lane k updated only where WSTRB[k]=1; WSTRB all-zero -> OKAY response, no change, wr_pulse not asserted.
REQ-012 BVALID asserts the cycle after commit, holds with stable BRESP until BREADY sampled high; holders clear on commit, so next AW/W accepted at earliest the cycle after commit (max one outstanding write).
REQ-013 wr_pulse[i] high exactly in the cycle register i updates (commit cycle + 1, coincident with BVALID rising).
REQ-014 Read path FSM states R_IDLE, R_DATA: R_IDLE ARREADY=1; ARVALID -> latch RDATA/RRESP, go R_DATA; R_DATA ARREADY=0, RVALID=1, RDATA/RRESP stable until RREADY, then R_IDLE. Read latency: RVALID the cycle after AR handshake.
REQ-015 Write FSM states W_IDLE (collecting), W_RESP (BVALID high); W_RESP -> W_IDLE on BREADY.
REQ-016 Simultaneous read AR handshake and write commit to the same register: read returns the pre-write value.
REQ-017 Read and write channels fully independent; neither stalls the other.
REQ-018 VALID outputs never depend combinationally on READY inputs; no combinational input-to-output paths.

Reset
REQ-019 While ARESET high: AWREADY, WREADY, ARREADY = 0; BVALID, RVALID = 0; BRESP, RRESP = 2'b00; RDATA = 0; all registers = 0; wr_pulse = 0; holders empty; FSMs in W_IDLE/R_IDLE.
REQ-020 READY outputs rise the first cycle after ARESET deasserts.
REQ-021 Reset mid-transaction abandons it: pending BVALID/RVALID drop, captured AW/W discarded, no register write.

Structure
REQ-022 Shared package axi4_lite_pkg SHALL hold the RESP encodings (OKAY 2'b00, SLVERR 2'b10) and the read/write FSM state typedefs.
REQ-023 Address decode/range check SHALL be a sub-module axi4_lite_addr_dec (combinational, instanced once for AW and once for AR).

Verification
REQ-024 Write 0xDEADBEEF to BASE_ADDR+0x8, WSTRB 4'hF, then read 0x8 -> BRESP 00, RDATA 0xDEADBEEF, RRESP 00, wr_pulse[2] single cycle.
REQ-025 W presented 3 cycles before AW (reg 0 preset 0x11223344, WDATA 0xAABBCCDD, WSTRB 4'b0101) -> reg 0 = 0x11BB33DD, one BVALID.
REQ-026 Write and read to BASE_ADDR+NUM_REGS*4 -> BRESP 10, RRESP 10, RDATA 0, reg_q unchanged.
REQ-027 BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; no new AW/W accepted until B completes.
REQ-028 Same-cycle AR and commit to reg 1 (old 0x5, new 0x9) -> RDATA 0x5; subsequent read -> 0x9.
REQ-029 ARESET asserted with RVALID and BVALID pending -> both 0 next cycle, registers 0, READYs 1 the cycle after release.
